// File: rtl/transpose_pkg.sv
// transpose_pkg: shared types and helpers for the streaming transpose buffer.
//   half_state_e     - lifecycle of one ping-pong half
//   idx_width()      - lane / row / column index width for an n-lane array
//   bank_addr_width()- bank address width ({half, row})
//   rotate()         - (index + offset) mod n, used for the diagonal bank skew
package transpose_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } half_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bank_addr_width(input int unsigned n);
    return idx_width(n) + 1;
  endfunction

  function automatic int unsigned rotate(input int unsigned idx,
                                         input int unsigned offset,
                                         input int unsigned n);
    return (idx + offset) % n;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: one storage bank of the transpose buffer.
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write address ({half, row})
//   wr_data - write data
//   rd_en   - read strobe; rd_data is updated one cycle later and holds otherwise
//   rd_addr - read address
//   rd_data - registered read data
module transpose_bank #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; every entry is written
  // before it is read, and the consumer qualifies rd_data with its own valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/transpose_buffer.sv
// transpose_buffer: streaming NUM_PE x NUM_PE matrix transposer.
// Rows enter one per cycle, columns (or rows, in pass-through) leave one per
// cycle. Element (r, j) lives in bank (j + r) mod NUM_PE at address {half, r},
// so each row write and each column read touches every bank exactly once.
//   clk, rst_n        - clock, synchronous active-low reset
//   in_valid/in_ready - row handshake; in_data carries NUM_PE lanes
//   in_transpose      - block mode, sampled with row 0 (1 = transpose)
//   out_valid/out_ready - vector handshake; out_data carries NUM_PE lanes
//   out_last          - final vector of a block
module transpose_buffer
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_PE     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   in_data,
  input  logic                           in_transpose,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0]   out_data,
  output logic                           out_last
);

  localparam int unsigned ADDR_WIDTH = idx_width(NUM_PE);
  localparam int unsigned BANK_DEPTH = 2 * NUM_PE;
  localparam int unsigned BANK_AW    = bank_addr_width(NUM_PE);

  typedef logic [ADDR_WIDTH-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_PE - 1);

  half_state_e state_q [2];
  half_state_e state_d [2];
  logic [1:0]  mode_q;                 // per half: 1 = transpose
  idx_t        wr_row_q, rd_col_q;
  logic        wr_buf_q, rd_buf_q;
  logic        s1_valid_q, s1_last_q;  // bank read in flight
  idx_t        s1_col_q;

  logic in_fire, out_take, rd_issue;

  assign in_fire  = in_valid && in_ready;
  // Output register can take new data when empty or being consumed; the bank
  // read stage advances on the same condition so it never overruns.
  assign out_take = !out_valid || out_ready;
  assign rd_issue = ((state_q[rd_buf_q] == FULL) || (state_q[rd_buf_q] == DRAINING))
                    && out_take;

  // ---------------- half state: register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- half state: next state ----------------
  // Writes only touch an EMPTY/FILLING half and reads only a FULL/DRAINING
  // half, so both updates can be applied independently.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d and no latch appears.
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (in_fire) begin
      if (wr_row_q == LAST_IDX)  state_d[wr_buf_q] = FULL;
      else if (wr_row_q == '0)   state_d[wr_buf_q] = FILLING;
    end
    if (rd_issue) begin
      if (rd_col_q == LAST_IDX)  state_d[rd_buf_q] = EMPTY;
      else if (rd_col_q == '0)   state_d[rd_buf_q] = DRAINING;
    end
  end

  // ---------------- half state: outputs ----------------
  always_comb begin
    in_ready = rst_n && ((state_q[wr_buf_q] == EMPTY) || (state_q[wr_buf_q] == FILLING));
  end

  // ---------------- counters, read pipeline, output register ----------------
  logic [NUM_PE*DATA_WIDTH-1:0] unrot_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_row_q   <= '0;
      wr_buf_q   <= 1'b0;
      rd_col_q   <= '0;
      rd_buf_q   <= 1'b0;
      mode_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_col_q   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      if (in_fire) begin
        wr_row_q <= wr_row_q + 1'b1;   // NUM_PE is a power of two: wraps to 0
        if (wr_row_q == '0)       mode_q[wr_buf_q] <= in_transpose;
        if (wr_row_q == LAST_IDX) wr_buf_q <= ~wr_buf_q;
      end
      if (rd_issue) begin
        rd_col_q  <= rd_col_q + 1'b1;
        s1_col_q  <= rd_col_q;
        s1_last_q <= (rd_col_q == LAST_IDX);
        if (rd_col_q == LAST_IDX) rd_buf_q <= ~rd_buf_q;
      end
      if (out_take) begin
        s1_valid_q <= rd_issue;
        out_valid  <= s1_valid_q;
        out_last   <= s1_valid_q && s1_last_q;
        if (s1_valid_q) out_data <= unrot_data;
      end
    end
  end

  // ---------------- banks with input rotation / output un-rotation ----------------
  logic [DATA_WIDTH-1:0] in_lane    [NUM_PE];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_PE];

  for (genvar b = 0; b < NUM_PE; b++) begin : g_bank
    idx_t wr_lane, rd_row, out_sel;

    assign in_lane[b] = in_data[b*DATA_WIDTH +: DATA_WIDTH];

    // Bank b holds lane (b - r) of row r.
    assign wr_lane = idx_t'(rotate(b, NUM_PE - 32'(wr_row_q), NUM_PE));
    // Transpose reads row (b - c) from bank b; pass-through reads row c everywhere.
    assign rd_row  = mode_q[rd_buf_q] ? idx_t'(rotate(b, NUM_PE - 32'(rd_col_q), NUM_PE))
                                      : rd_col_q;
    // Output lane b comes from bank (b + c) in both modes.
    assign out_sel = idx_t'(rotate(b, 32'(s1_col_q), NUM_PE));
    assign unrot_data[b*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[out_sel];

    transpose_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH),
      .AW         (BANK_AW)
    ) u_bank (
      .clk     (clk),
      .wr_en   (in_fire),
      .wr_addr ({wr_buf_q, wr_row_q}),
      .wr_data (in_lane[wr_lane]),
      .rd_en   (rd_issue),
      .rd_addr ({rd_buf_q, rd_row}),
      .rd_data (bank_rdata[b])
    );
  end

  // A write and a read in the same cycle must always address different halves.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(in_fire && rd_issue && (wr_buf_q == rd_buf_q)));

endmodule

// File: doc/transpose_buffer.md
Name: transpose_buffer

Overview:
- Streaming NUM_PE x NUM_PE matrix transposer for the PE array.
- Accepts one row vector per cycle and emits one column vector per cycle.
- Storage is NUM_PE single-port-per-direction banks with diagonal skew, so there are no bank conflicts.
- Ping-pong halves let block k+1 fill while block k drains; a per-block mode selects transpose or pass-through.

Parameters:
- DATA_WIDTH, 64, bits per element.
- NUM_PE, 8, matrix dimension, lane count and bank count. Must be a power of two, >= 2.
- localparam ADDR_WIDTH = $clog2(NUM_PE).
- localparam BANK_DEPTH = 2*NUM_PE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  buffer can accept a row.
- in_data  in  NUM_PE*DATA_WIDTH  row vector; lane j = bits [j*DATA_WIDTH +: DATA_WIDTH].
- in_transpose  in  1  mode of the block. Sampled with row 0 only: 1 = transpose, 0 = pass-through.
- out_valid  out  1  output vector valid.
- out_ready  in  1  consumer accepts the output vector.
- out_data  out  NUM_PE*DATA_WIDTH  column vector (or row in pass-through); lane layout as in_data.
- out_last  out  1  marks the final vector of a block.

Behaviour:
- Reset (rst_n=0 at posedge): discards any partial or full block, with no flush.
  - Both halves EMPTY; wr_row=0, wr_buf=0, rd_col=0, rd_buf=0.
  - out_valid=0, out_last=0, out_data=0, in_ready=0 during reset.
  - Bank contents are not reset.
- Half state per buffer h: EMPTY -> FILLING (row 0 accepted) -> FULL (row NUM_PE-1 accepted) -> DRAINING (column 0 issued) -> EMPTY (column NUM_PE-1 issued).
- in_ready = (state[wr_buf] == EMPTY or FILLING). A row is accepted when in_valid && in_ready.
- Write, row r (= wr_row), lane j:
  - Goes to bank (j+r) mod NUM_PE, address {wr_buf, r}.
  - Every bank is written exactly once per accepted row.
  - On r = NUM_PE-1: wr_row wraps to 0, state -> FULL, wr_buf toggles.
- Mode is latched per half at row 0.
- Read issue:
  - Allowed when state[rd_buf] is FULL or DRAINING and the output register is free or draining (!out_valid || out_ready).
  - Transpose, column c: output lane r <- bank (r+c) mod NUM_PE, addr {rd_buf, r}.
  - Pass-through, row c: output lane j <- bank (j+c) mod NUM_PE, addr {rd_buf, c}.
  - On the issue of c = NUM_PE-1: the half becomes EMPTY, rd_col wraps, rd_buf toggles.
- Read latency:
  - Banks are read synchronously (1 cycle); the un-rotation mux feeds the out_data register.
  - out_valid rises exactly 2 cycles after the final-row handshake when the output path is idle.
- Backpressure: out_data, out_valid and out_last hold stable while out_valid && !out_ready. No vector is dropped or duplicated.
- Throughput: with in_valid=out_ready=1 continuously, sustains 1 row in and 1 vector out per cycle, with in_ready never deasserting after the first block.
- Simultaneous events:
  - A write into half A and a read from half B in the same cycle are always legal.
  - A half freed on its last read issue may be written the next cycle. Its data is already captured, so no bypass is needed.
- Writes and reads never target the same half; any same-address read/write is a design error (assertion).
- Both halves FULL: in_ready=0 until the first column of rd_buf is issued and the last one frees it.

Decomposition:
- Package transpose_pkg:
  - lane index and address widths as functions of NUM_PE;
  - half_state_e enum {EMPTY, FILLING, FULL, DRAINING};
  - rotation helper function (index + offset) mod NUM_PE.
- Sub-module transpose_bank:
  - one bank, DATA_WIDTH x BANK_DEPTH;
  - one write port and one registered read port with read enable;
  - NUM_PE instances.
- Parent holds: counters, half state, input rotation, output un-rotation, output register.

Test Plan (NUM_PE=4, DATA_WIDTH=16):
- Element values are 0xRC (R = row, C = column).
- Transpose, single block: rows {0x00,0x01,0x02,0x03} .. {0x30,..,0x33}, out_ready=1.
  - Outputs: {0x00,0x10,0x20,0x30} .. {0x03,0x13,0x23,0x33}.
  - out_last on the 4th output; first out_valid 2 cycles after the last row.
- Pass-through: same rows with in_transpose=0 -> output equals input rows in order.
- Back-to-back 3 blocks, alternating mode, continuous valid/ready:
  - in_ready stays 1;
  - 12 outputs, each correct per its block's mode, no bubbles after the first.
- Backpressure: out_ready=0 for 10 cycles mid-block.
  - out_data held; in_ready falls after the 2nd block fills (both halves FULL).
  - On release, all 8 vectors are delivered in order.
- Reset mid-operation: rst_n=0 after 2 rows of a block and during a drain.
  - Next cycle out_valid=0 and out_data=0; in_ready=1 after release.
  - A fresh block transposes correctly with no stale data.
- Random valid/ready (50%) over 200 blocks against a scoreboard model: no loss, no duplication, ordering preserved.
